// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: input synchronization, button debounce and press detection,
// and the run/pause/adjust FSM that strobes the seconds/minutes counters.
module stopwatch_ctrl #(
    parameter int unsigned DEB_CNT = 500000,
    parameter int unsigned DEB_W   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       sw_sel,
    input  logic       sw_adj,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       sec_at_max,
    output logic       sec_en,
    output logic       min_en,
    output logic       clr,
    output logic       paused,
    output logic [3:0] mode
);

    localparam logic [DEB_W-1:0] DebLast = DEB_W'(DEB_CNT - 1);

    typedef enum logic [1:0] {StRun, StPause, StAdjSec, StAdjMin} state_e;

    // Bit order: [0] btn_pause, [1] btn_clr, [2] sw_sel, [3] sw_adj
    logic [3:0] async_in;
    logic [3:0] meta_q, sync_q;
    // Marks the synchronizer output as meaningful once two post-reset samples exist
    logic [1:0] sync_vld_q;

    assign async_in = {sw_adj, sw_sel, btn_clr, btn_pause};

    // Two-flop synchronizers for all asynchronous inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            sync_vld_q <= '0;
        end else begin
            meta_q     <= async_in;
            sync_q     <= meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    // Debounce state for the two buttons: index 0 = pause, 1 = clear
    logic [DEB_W-1:0] cnt_q [2];
    logic [DEB_W-1:0] cnt_d [2];
    logic [1:0]       acc_q, acc_d;
    logic [1:0]       acc_dly_q;
    // A button held through reset must be seen released before it may raise an event
    logic [1:0]       armed_q, armed_d;
    logic [1:0]       press;

    // Debounce counters, arming and press detection
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            acc_d[i] = acc_q[i];
            if (sync_q[i] == acc_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DebLast) begin
                acc_d[i] = sync_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DEB_W'(1);
            end
            armed_d[i] = armed_q[i] | (sync_vld_q[1] & ~sync_q[i]);
            press[i]   = acc_q[i] & ~acc_dly_q[i] & armed_q[i];
        end
    end

    // Debounce registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            acc_q     <= '0;
            acc_dly_q <= '0;
            armed_q   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            acc_q     <= acc_d;
            acc_dly_q <= acc_q;
            armed_q   <= armed_d;
        end
    end

    state_e     state_q, state_d;
    logic       paused_q, paused_d;
    logic       sec_en_q, sec_en_d;
    logic       min_en_q, min_en_d;
    logic       clr_q, clr_d;
    logic [3:0] mode_q, mode_d;

    // FSM state, flag and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            paused_q <= 1'b0;
            sec_en_q <= 1'b0;
            min_en_q <= 1'b0;
            clr_q    <= 1'b0;
            mode_q   <= 4'b0011;
        end else begin
            state_q  <= state_d;
            paused_q <= paused_d;
            sec_en_q <= sec_en_d;
            min_en_q <= min_en_d;
            clr_q    <= clr_d;
            mode_q   <= mode_d;
        end
    end

    // Next state; uses the updated pause flag so state and flag move together
    always_comb begin
        paused_d = paused_q ^ press[0];
        if (sync_q[3]) begin
            state_d = sync_q[2] ? StAdjMin : StAdjSec;
        end else begin
            state_d = paused_d ? StPause : StRun;
        end
    end

    // Output decode: strobes from current state, mode from next state, clear overrides ticks
    always_comb begin
        sec_en_d = 1'b0;
        min_en_d = 1'b0;
        clr_d    = press[1];
        unique case (state_q)
            StRun: begin
                sec_en_d = tick_1hz;
                min_en_d = tick_1hz & sec_at_max;
            end
            StPause:  ;
            StAdjSec: sec_en_d = tick_2hz;
            StAdjMin: min_en_d = tick_2hz;
        endcase
        if (press[1]) begin
            sec_en_d = 1'b0;
            min_en_d = 1'b0;
        end
        unique case (state_d)
            StRun:    mode_d = 4'b0011;
            StPause:  mode_d = 4'b0000;
            StAdjSec: mode_d = 4'b0100;
            StAdjMin: mode_d = 4'b1000;
        endcase
    end

    assign sec_en = sec_en_q;
    assign min_en = min_en_q;
    assign clr    = clr_q;
    assign paused = paused_q;
    assign mode   = mode_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a small expected-value scoreboard.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_pause, btn_clr, sw_sel, sw_adj;
    logic       tick_1hz, tick_2hz, sec_at_max;
    logic       sec_en, min_en, clr, paused;
    logic [3:0] mode;

    stopwatch_ctrl #(
        .DEB_CNT(4),
        .DEB_W  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pause (btn_pause),
        .btn_clr   (btn_clr),
        .sw_sel    (sw_sel),
        .sw_adj    (sw_adj),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .sec_at_max(sec_at_max),
        .sec_en    (sec_en),
        .min_en    (min_en),
        .clr       (clr),
        .paused    (paused),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    // {clr, min_en, sec_en, paused, mode}
    logic [7:0] status;
    assign status = {clr, min_en, sec_en, paused, mode};

    int n_sec = 0;
    int n_min = 0;
    always @(negedge clk) begin
        if (sec_en) n_sec <= n_sec + 1;
        if (min_en) n_min <= n_min + 1;
    end

    logic [7:0] exp_q[$];
    string      tag_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_push(input string tag, input logic [7:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic sb_check(input logic [7:0] obs);
        string      t;
        logic [7:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %b expected <none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %b expected %b", t, obs, e);
            end
        end
    endtask

    // One-cycle tick strobes; returns on the negedge after the capturing edge
    task automatic pulse(input logic t1, input logic t2);
        tick_1hz = t1;
        tick_2hz = t2;
        step(1);
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
    endtask

    task automatic press_pause();
        btn_pause = 1'b1;
        step(10);
        btn_pause = 1'b0;
        step(10);
    endtask

    int s0, m0;

    initial begin
        rst = 1'b1;
        btn_pause = 1'b0; btn_clr = 1'b0; sw_sel = 1'b0; sw_adj = 1'b0;
        tick_1hz = 1'b0; tick_2hz = 1'b0; sec_at_max = 1'b0;
        step(3);
        sb_push("reset_state", 8'h03);
        sb_check(status);
        rst = 1'b0;
        step(5);
        sb_push("run_idle", 8'h03);
        sb_check(status);

        // RUN: seconds strobe, then carry
        sb_push("run_tick1_sec", 8'h23);
        pulse(1'b1, 1'b0);
        sb_check(status);
        sb_push("run_sec_one_cycle", 8'h03);
        step(1);
        sb_check(status);
        sec_at_max = 1'b1;
        sb_push("run_carry", 8'h63);
        pulse(1'b1, 1'b0);
        sb_check(status);
        sb_push("run_carry_one_cycle", 8'h03);
        step(1);
        sb_check(status);
        sec_at_max = 1'b0;
        sb_push("run_ignores_tick2", 8'h03);
        pulse(1'b0, 1'b1);
        sb_check(status);

        // Bounce shorter than the debounce window
        sb_push("bounce_no_event", 8'h03);
        for (int i = 0; i < 10; i++) begin
            btn_pause = ~btn_pause;
            step(2);
        end
        btn_pause = 1'b0;
        step(10);
        sb_check(status);

        // Clean hold: 2 sync + 4 debounce + 1 toggle cycles
        btn_pause = 1'b1;
        sb_push("pause_not_yet", 8'h03);
        step(6);
        sb_check(status);
        sb_push("pause_set", 8'h10);
        step(1);
        sb_check(status);
        sb_push("pause_single_event", 8'h10);
        step(3);
        sb_check(status);
        sb_push("pause_blocks_tick1", 8'h10);
        pulse(1'b1, 1'b0);
        sb_check(status);
        btn_pause = 1'b0;
        sb_push("release_no_event", 8'h10);
        step(10);
        sb_check(status);
        sb_push("resume_run", 8'h03);
        press_pause();
        sb_check(status);

        // Clear coincident with tick_1hz
        btn_clr = 1'b1;
        step(6);
        tick_1hz = 1'b1;
        sb_push("clr_wins_over_tick", 8'h83);
        step(1);
        sb_check(status);
        tick_1hz = 1'b0;
        sb_push("clr_one_cycle", 8'h03);
        step(1);
        sb_check(status);
        btn_clr = 1'b0;
        sb_push("clr_release_quiet", 8'h03);
        step(10);
        sb_check(status);

        // Minutes adjust
        sw_adj = 1'b1;
        sw_sel = 1'b1;
        sb_push("adj_min_mode", 8'h08);
        step(3);
        sb_check(status);
        s0 = n_sec;
        m0 = n_min;
        sb_push("adj_min_count", 8'd3);
        sb_push("adj_min_no_sec", 8'd0);
        pulse(1'b0, 1'b1); step(2);
        pulse(1'b1, 1'b1); step(2);
        pulse(1'b0, 1'b1); step(2);
        sb_check(8'(n_min - m0));
        sb_check(8'(n_sec - s0));
        sb_push("adj_pause_flag_only", 8'h18);
        press_pause();
        sb_check(status);
        sw_sel = 1'b0;
        sb_push("adj_sec_mode", 8'h14);
        step(3);
        sb_check(status);
        sb_push("adj_sec_tick2", 8'h34);
        pulse(1'b0, 1'b1);
        sb_check(status);
        sw_adj = 1'b0;
        sb_push("leave_adj_to_pause", 8'h10);
        step(3);
        sb_check(status);

        // Reset during adjust with the pause button held
        sw_adj = 1'b1;
        sb_push("adj_again", 8'h14);
        step(3);
        sb_check(status);
        btn_pause = 1'b1;
        step(4);
        rst = 1'b1;
        sw_adj = 1'b0;
        sb_push("mid_adjust_reset", 8'h03);
        step(1);
        sb_check(status);
        rst = 1'b0;
        sb_push("held_through_reset", 8'h03);
        step(15);
        sb_check(status);
        btn_pause = 1'b0;
        sb_push("held_release_quiet", 8'h03);
        step(10);
        sb_check(status);
        btn_pause = 1'b1;
        sb_push("repress_event", 8'h10);
        step(10);
        sb_check(status);
        btn_pause = 1'b0;
        step(5);

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The module SHALL have parameter DEB_CNT, default 500000: number of consecutive stable clk cycles before a button level is accepted.
REQ-002 The module SHALL have parameter DEB_W, default 20: debounce counter width; DEB_CNT SHALL satisfy DEB_CNT <= 2^DEB_W - 1.
REQ-003 clk  in  1  system clock; all state SHALL be on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 btn_pause  in  1  raw pause button, asynchronous and bouncy.
REQ-006 btn_clr  in  1  raw clear button, asynchronous and bouncy.
REQ-007 sw_sel  in  1  adjust field select: 0 = seconds, 1 = minutes; asynchronous.
REQ-008 sw_adj  in  1  adjust mode request; asynchronous.
REQ-009 tick_1hz  in  1  one-cycle run strobe from the clock divider.
REQ-010 tick_2hz  in  1  one-cycle adjust strobe from the clock divider.
REQ-011 sec_at_max  in  1  seconds counter currently holds 59.
REQ-012 sec_en  out  1  one-cycle seconds-increment strobe.
REQ-013 min_en  out  1  one-cycle minutes-increment strobe.
REQ-014 clr  out  1  one-cycle synchronous clear for both counters.
REQ-015 paused  out  1  pause flag.
REQ-016 mode  out  4  [0] run-count active, [1] minute carry enabled, [2] seconds adjust, [3] minutes adjust.

Function
REQ-017 btn_pause, btn_clr, sw_sel and sw_adj SHALL each pass through a 2-flop synchronizer.
REQ-018 Each synchronized button SHALL drive its own debounce counter:
- counter clears while the synced level equals the accepted level;
- counter increments while the levels differ;
- on reaching DEB_CNT-1, the accepted level updates and the counter clears.
REQ-019 A press event SHALL be a one-cycle pulse on the cycle after the accepted level rises 0->1; releases SHALL generate no event.
REQ-020 The switches SHALL be synchronized only, not debounced.
REQ-021 The FSM states SHALL be RUN, PAUSE, ADJ_SEC and ADJ_MIN.
REQ-022 FSM transitions SHALL be:
- synced sw_adj=1: go to ADJ_MIN if synced sw_sel=1, otherwise ADJ_SEC; re-evaluated every cycle, so changing sw_sel switches between the two ADJ states;
- synced sw_adj=0 in an ADJ state: go to PAUSE if paused=1, otherwise RUN;
- in RUN or PAUSE: go to PAUSE when paused=1, RUN when paused=0.
REQ-023 A pause event SHALL toggle paused in every state; in ADJ states it SHALL change only the flag, not the current state.
REQ-024 A clear event SHALL pulse clr for exactly one cycle in any state and SHALL leave paused and the state unchanged.
REQ-025 sec_en and min_en SHALL be registered, asserting one cycle after the qualifying tick:
- RUN: sec_en = tick_1hz; min_en = tick_1hz & sec_at_max;
- PAUSE: both 0;
- ADJ_SEC: sec_en = tick_2hz; min_en = 0, with no carry;
- ADJ_MIN: min_en = tick_2hz; sec_en = 0.
REQ-026 When a clear event and a qualifying tick occur in the same cycle, clr SHALL win: sec_en=0 and min_en=0 on the following cycle.
REQ-027 The mode output SHALL be registered from the next state:
- RUN = 4'b0011;
- PAUSE = 4'b0000;
- ADJ_SEC = 4'b0100;
- ADJ_MIN = 4'b1000.
REQ-028 Coincident tick_1hz and tick_2hz SHALL each act only in the state that uses it.

Reset
REQ-029 While rst=1, the following SHALL be held at 0:
- state = RUN;
- paused;
- sec_en, min_en and clr;
- all synchronizer flops, accepted levels and debounce counters.
REQ-030 While rst=1, mode SHALL be held at 4'b0011.
REQ-031 Assertion of rst mid-debounce or mid-adjust SHALL discard all progress; no event SHALL be generated from a button already held at release of rst until its accepted level has risen 0->1 after release.

Verification (DEB_CNT=4)
REQ-032 Hold btn_pause=1 for 10 cycles -> exactly one pause event; paused=1 at about cycle 2+4+1; mode=0000; tick_1hz then gives sec_en=0.
REQ-033 Toggle btn_pause every 2 cycles for 20 cycles, then hold 0 -> no event; paused unchanged.
REQ-034 RUN with sec_at_max=1 and a tick_1hz pulse -> sec_en=1 and min_en=1 on the next cycle, each for exactly 1 cycle.
REQ-035 Set sw_adj=1, sw_sel=1 and pulse tick_2hz three times -> three min_en pulses, zero sec_en, mode=1000; a pause press sets paused=1; sw_adj=0 -> PAUSE, mode=0000.
REQ-036 Clear event in the same cycle as tick_1hz -> clr=1 for one cycle; sec_en=0; paused unchanged.
REQ-037 Assert rst for 1 cycle during adjust while btn_pause is held -> outputs reset per REQ-029 and REQ-030; no pause event until the button is released and pressed again.
